// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: shares one multi-precision adder/subtractor among N_REQ requesters, round-robin.
// Latency: request seen in IDLE at cycle 0 -> add_start at 1 -> resp_valid at D+2 (D = start-to-done); next grant D+3.
// Backpressure: one operation in flight; requesters hold req_valid and operands until their resp_valid pulse.
//
// Ports:
//   clk, resetn       clock; asynchronous reset, active-high despite the name (kept for the integrating netlist)
//   req_valid/sub     per-requester request level and op select (1 = a-b)
//   req_a/req_b       flattened operands, slice i belongs to requester i
//   resp_valid/err    one-hot completion pulse; err qualifies it and marks a watchdog abort
//   resp_result       WIDTH+1 result, held until the next completion
//   busy, grant_idx   not-IDLE flag; current or last granted requester
//   add_*             shared adder: start pulse, op select, registered operands, result, done pulse
module mpadder_arbiter #(
   parameter int N_REQ   = 2,
   parameter int WIDTH   = 1027,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_sub,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       resp_valid,
   output logic                   resp_err,
   output logic [WIDTH:0]         resp_result,
   output logic                   busy,
   output logic [2:0]             grant_idx,
   output logic                   add_start,
   output logic                   add_subtract,
   output logic [WIDTH-1:0]       add_in_a,
   output logic [WIDTH-1:0]       add_in_b,
   input  logic [WIDTH:0]         add_result,
   input  logic                   add_done
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q;
   logic [2:0]       rr_ptr_q;
   logic [2:0]       grant_q;
   logic [WD_W-1:0]  wd_cnt_q;
   logic [WD_W-1:0]  wd_cnt_d;
   logic             wd_expired;
   logic [N_REQ-1:0] resp_valid_q;
   logic             resp_err_q;
   logic [WIDTH:0]   resp_result_q;
   logic             busy_q;
   logic             add_start_q;
   logic             add_sub_q;
   logic [WIDTH-1:0] add_a_q;
   logic [WIDTH-1:0] add_b_q;

   // Requester views padded to 8 entries so a 3-bit index is always in range,
   // whatever N_REQ is; unused entries read as idle with zero operands.
   logic [7:0]       req_pad;
   logic [7:0]       sub_pad;
   logic [WIDTH-1:0] a_arr [8];
   logic [WIDTH-1:0] b_arr [8];

   logic [2:0]       cand;
   logic [2:0]       gnt_sel;
   logic             gnt_found;
   logic [7:0]       gnt_onehot;

   assign req_pad = 8'(req_valid);
   assign sub_pad = 8'(req_sub);

   for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < N_REQ) begin : g_live
         assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      end else begin : g_pad
         assign a_arr[gi] = '0;
         assign b_arr[gi] = '0;
      end
   end

   // Increment modulo N_REQ.
   function automatic logic [2:0] next_idx(input logic [2:0] v);
      return (v == 3'(N_REQ - 1)) ? 3'd0 : v + 3'd1;
   endfunction

   // Round-robin search: first set request starting at rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_sel   = 3'd0;
      cand      = rr_ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (!gnt_found && req_pad[cand]) begin
            gnt_found = 1'b1;
            gnt_sel   = cand;
         end
         cand = next_idx(cand);
      end
   end

   // Watchdog expires on the WAIT cycle whose increment would reach TIMEOUT,
   // so the abort response lands TIMEOUT+1 cycles after the ISSUE cycle.
   assign wd_cnt_d   = wd_cnt_q + WD_W'(1);
   assign wd_expired = (wd_cnt_d == WD_W'(TIMEOUT));
   assign gnt_onehot = 8'd1 << grant_q;

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= 3'd0;
         grant_q       <= 3'd0;
         wd_cnt_q      <= '0;
         resp_valid_q  <= '0;
         resp_err_q    <= 1'b0;
         resp_result_q <= '0;
         busy_q        <= 1'b0;
         add_start_q   <= 1'b0;
         add_sub_q     <= 1'b0;
         add_a_q       <= '0;
         add_b_q       <= '0;
      end else begin
         // Both pulses last exactly the one state they are raised for.
         add_start_q  <= 1'b0;
         resp_valid_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (gnt_found) begin
                  grant_q     <= gnt_sel;
                  add_a_q     <= a_arr[gnt_sel];
                  add_b_q     <= b_arr[gnt_sel];
                  add_sub_q   <= sub_pad[gnt_sel];
                  add_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A done seen here belongs to nothing we issued; it is ignored.
               wd_cnt_q <= '0;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (add_done) begin
                  resp_result_q <= add_result;
                  resp_err_q    <= 1'b0;
                  resp_valid_q  <= gnt_onehot[N_REQ-1:0];
                  state_q       <= S_RESP;
               end else if (wd_expired) begin
                  resp_result_q <= '0;
                  resp_err_q    <= 1'b1;
                  resp_valid_q  <= gnt_onehot[N_REQ-1:0];
                  state_q       <= S_RESP;
               end else begin
                  wd_cnt_q <= wd_cnt_d;
               end
            end
            S_RESP: begin
               rr_ptr_q <= next_idx(grant_q);
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign resp_valid   = resp_valid_q;
   assign resp_err     = resp_err_q;
   assign resp_result  = resp_result_q;
   assign busy         = busy_q;
   assign grant_idx    = grant_q;
   assign add_start    = add_start_q;
   assign add_subtract = add_sub_q;
   assign add_in_a     = add_a_q;
   assign add_in_b     = add_b_q;

`ifndef SYNTHESIS
   a_resp_onehot: assert property (@(posedge clk) disable iff (resetn)
      $onehot0(resp_valid_q));
   a_start_in_issue: assert property (@(posedge clk) disable iff (resetn)
      add_start_q |-> (state_q == S_ISSUE));
   a_ops_stable: assert property (@(posedge clk) disable iff (resetn)
      (state_q inside {S_WAIT, S_RESP}) |->
         ($stable(add_a_q) && $stable(add_b_q) && $stable(add_sub_q)));
`endif

endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb_mpadder_arbiter: drives directed and random requests, models the adder, scores responses.
// Latency: checks grant at cycle 1 and response at D+2 (or TIMEOUT+2 on a hung adder).
// Backpressure: requests persist until served; fairness bound checked per service.
module tb_mpadder_arbiter;
   localparam int N  = 3;
   localparam int W  = 1027;
   localparam int TO = 15;

   logic           clk = 1'b0;
   logic           resetn;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_sub;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   resp_valid;
   logic           resp_err;
   logic [W:0]     resp_result;
   logic           busy;
   logic [2:0]     grant_idx;
   logic           add_start;
   logic           add_subtract;
   logic [W-1:0]   add_in_a;
   logic [W-1:0]   add_in_b;
   logic [W:0]     add_result = '0;
   logic           add_done;

   logic model_done = 1'b0;
   logic stray_done = 1'b0;
   assign add_done = model_done | stray_done;

   int dly  = 1;
   bit hang = 1'b0;
   int cnt  = 0;

   logic [W-1:0] op_a [N];
   logic [W-1:0] op_b [N];
   logic         op_s [N];
   int           rr_m = 0;
   int           pend_ops [N];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [N-1:0] pend;
   logic [N-1:0] add_bits;

   mpadder_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_sub     (req_sub),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_err    (resp_err),
      .resp_result (resp_result),
      .busy        (busy),
      .grant_idx   (grant_idx),
      .add_start   (add_start),
      .add_subtract(add_subtract),
      .add_in_a    (add_in_a),
      .add_in_b    (add_in_b),
      .add_result  (add_result),
      .add_done    (add_done)
   );

   always #5 clk = ~clk;

   // Adder model: samples operands on start, pulses done D cycles later.
   always @(posedge clk) begin
      #1;
      if (resetn) begin
         cnt        = 0;
         model_done = 1'b0;
      end else if (add_start) begin
         cnt        = hang ? 0 : dly;
         model_done = 1'b0;
         add_result = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                   : ({1'b0, add_in_a} + {1'b0, add_in_b});
      end else if (cnt > 0) begin
         cnt        = cnt - 1;
         model_done = (cnt == 0);
      end else begin
         model_done = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", tag,
                  got[W -: 64], got[63:0], exp[W -: 64], exp[63:0]);
      end
   endtask

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
         req_sub[i]      = op_s[i];
      end
   endtask

   // Called on the falling edge of an IDLE cycle (cycle 0); returns on the
   // falling edge of the following IDLE cycle.
   task automatic run_op(input logic [N-1:0] mask, input int d, input bit hg,
                         input bit poke, input bit stray_iss, input bit keep);
      int         w;
      int         k;
      int         exp_k;
      bit         seen;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      logic       s0;
      logic [W:0] exp_res;
      dly  = d;
      hang = hg;
      req_valid = mask;
      drive_ops();
      w = -1;
      for (int i = 0; i < N; i++) begin
         int c = (rr_m + i) % N;
         if (w < 0 && mask[c]) w = c;
      end
      a0 = op_a[w];
      b0 = op_b[w];
      s0 = op_s[w];
      exp_res = hg ? '0 : (s0 ? ({1'b0, a0} - {1'b0, b0}) : ({1'b0, a0} + {1'b0, b0}));
      exp_k   = hg ? TO + 2 : d + 2;
      chk("fairness", (pend_ops[w] <= N - 1), 1);
      for (int i = 0; i < N; i++) begin
         if (i == w || !mask[i]) pend_ops[i] = 0;
         else                    pend_ops[i]++;
      end
      @(negedge clk);
      chk("start", add_start, 1);
      chk("subsel", add_subtract, s0);
      chk("in_a", add_in_a, a0);
      chk("in_b", add_in_b, b0);
      chk("grant", grant_idx, w);
      chk("busy", busy, 1);
      if (stray_iss) stray_done = 1'b1;
      seen = 1'b0;
      k    = 1;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         stray_done = 1'b0;
         if (poke && k == 3) begin
            op_a[w] = rand_wide();
            drive_ops();
         end
         if (resp_valid != '0) begin
            seen = 1'b1;
            chk("latency", k, exp_k);
            chk("resp_onehot", resp_valid, 1 << w);
            chk("resp_err", resp_err, hg);
            chk("resp_result", resp_result, exp_res);
            chk("hold_a", add_in_a, a0);
            chk("resp_start", add_start, 0);
         end
      end
      chk("resp_seen", seen, 1);
      if (!keep) req_valid[w] = 1'b0;
      rr_m = (w + 1) % N;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("rv_clear", resp_valid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "bench time limit");
   end

   initial begin
      resetn    = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         op_s[i] = 1'b0;
         pend_ops[i] = 0;
      end
      drive_ops();
      repeat (3) @(negedge clk);
      chk("rst_rv", resp_valid, 0);
      chk("rst_err", resp_err, 0);
      chk("rst_res", resp_result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_idx, 0);
      chk("rst_start", add_start, 0);
      chk("rst_sub", add_subtract, 0);
      chk("rst_a", add_in_a, 0);
      chk("rst_b", add_in_b, 0);
      resetn = 1'b0;
      @(negedge clk);
      chk("post_rst_start", add_start, 0);

      // Single add.
      op_a[0] = W'(5); op_b[0] = W'(3); op_s[0] = 1'b0;
      run_op(3'b001, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("add_eq8", resp_result, 8);

      // Subtract with borrow.
      op_a[1] = W'(3); op_b[1] = W'(5); op_s[1] = 1'b1;
      run_op(3'b010, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sub_borrow", resp_result, {1'b1, {(W-1){1'b1}}, 1'b0});

      // Contention between 0 and 1, three operations each.
      for (int j = 0; j < 6; j++) begin
         if (j == 0 || j == 1 || j == 2 || j == 3) begin
            op_a[j % 2] = rand_wide(); op_b[j % 2] = rand_wide();
            op_s[j % 2] = 1'($urandom_range(0, 1));
         end
         run_op((j < 5) ? 3'b011 : 3'b010, 1 + (j % 3), 1'b0, 1'b0, 1'b0, (j < 4));
      end

      // Hung adder, then a normal request.
      op_a[2] = rand_wide(); op_b[2] = rand_wide(); op_s[2] = 1'b0;
      run_op(3'b100, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(3'b100, 1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stray done in IDLE, then stray done in ISSUE plus operand change in WAIT.
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_start", add_start, 0);
      chk("stray_idle_rv", resp_valid, 0);
      op_a[1] = rand_wide(); op_b[1] = rand_wide(); op_s[1] = 1'b1;
      run_op(3'b010, 4, 1'b0, 1'b1, 1'b1, 1'b0);

      // Leave rr pointer at 1, then reset in the middle of WAIT.
      run_op(3'b001, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      hang      = 1'b1;
      req_valid = 3'b100;
      @(negedge clk);
      chk("rst_op_start", add_start, 1);
      chk("rst_op_grant", grant_idx, 2);
      repeat (3) @(negedge clk);
      req_valid = '0;
      resetn    = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant_idx, 0);
      chk("mid_rst_a", add_in_a, 0);
      chk("mid_rst_sub", add_subtract, 0);
      chk("mid_rst_res", resp_result, 0);
      @(negedge clk);
      resetn     = 1'b0;
      rr_m       = 0;
      stray_done = 1'b1;
      for (int i = 0; i < N; i++) pend_ops[i] = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         stray_done = 1'b0;
         chk("after_rst_rv", resp_valid, 0);
         chk("after_rst_busy", busy, 0);
         chk("after_rst_start", add_start, 0);
      end
      hang = 1'b0;
      op_a[0] = rand_wide(); op_b[0] = rand_wide(); op_s[0] = 1'b0;
      op_a[2] = rand_wide(); op_b[2] = rand_wide(); op_s[2] = 1'b1;
      run_op(3'b101, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      req_valid = '0;

      // Random traffic: requests persist until served.
      pend = '0;
      for (int t = 0; t < 40; t++) begin
         add_bits = N'($urandom_range(0, (1 << N) - 1));
         if ((pend | add_bits) == '0) add_bits = N'(1 << $urandom_range(0, N - 1));
         for (int i = 0; i < N; i++) begin
            if (add_bits[i] && !pend[i]) begin
               op_a[i] = rand_wide();
               op_b[i] = rand_wide();
               op_s[i] = 1'($urandom_range(0, 1));
            end
         end
         pend = pend | add_bits;
         run_op(pend, $urandom_range(1, 6), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         pend = req_valid;
      end
      req_valid = '0;
      repeat (2) @(negedge clk);
      chk("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mpadder_arbiter.md
Name: mpadder_arbiter

Overview:
- Shares one multi-precision adder/subtractor among N_REQ requesters, for example the Montgomery multiplier and the exponentiation controller.
- Arbitration is round-robin. The block latches the winner's operands, issues a one-cycle start to the adder, waits for its done pulse, and returns the 1028-bit result to the winner with a one-cycle valid pulse.
- Includes a watchdog for a hung adder.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 1027, operand width; result is WIDTH+1.
- TIMEOUT, 15, maximum cycles in WAIT before error abort.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-high (asserted = 1).
- req_valid  in  N_REQ  per-requester request level.
- req_sub  in  N_REQ  per-requester op select: 1 = a-b, 0 = a+b.
- req_a  in  N_REQ*WIDTH  flattened operand a; slice i belongs to requester i.
- req_b  in  N_REQ*WIDTH  flattened operand b.
- resp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = watchdog abort.
- resp_result  out  WIDTH+1  result, held until the next completion.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  3  index of the current or last granted requester.
- add_start  out  1  adder start pulse.
- add_subtract  out  1  adder op select.
- add_in_a  out  WIDTH  registered operand a to the adder.
- add_in_b  out  WIDTH  registered operand b to the adder.
- add_result  in  WIDTH+1  adder result.
- add_done  in  1  adder completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; watchdog counter = 0. Asserting resetn at any time, including mid-operation, aborts immediately. No resp_valid is generated for the aborted operation, and add_start is 0 the cycle after reset deasserts.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, no request: if req_valid == 0, stay in IDLE.
- IDLE, request present: winner g = first set bit of req_valid searching from rr_ptr upward, wrapping modulo N_REQ. Latch req_a[g], req_b[g] and req_sub[g] into add_in_a, add_in_b and add_subtract; set grant_idx = g; go to ISSUE.
- ISSUE: add_start = 1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT, normal completion: on add_done = 1, capture add_result into resp_result, set resp_err = 0, go to RESP.
- WAIT, timeout: otherwise increment the watchdog. When it reaches TIMEOUT without add_done, set resp_result = 0, set resp_err = 1, go to RESP.
- RESP: resp_valid[grant_idx] = 1 for exactly one cycle; rr_ptr = (grant_idx+1) mod N_REQ; go to IDLE.
- Stray done: add_done outside WAIT is ignored, including a done arriving in the ISSUE cycle.
- Operand stability: add_in_a, add_in_b and add_subtract stay constant from ISSUE until the next IDLE grant. The adder samples its operands on start, so they must not change before done.
- Requester protocol: hold req_valid, operands and req_sub stable from assertion until resp_valid. Drop req_valid on the clock edge that samples resp_valid, or keep it high to request again.
  - The arbiter samples req_valid only in IDLE.
  - A request dropped after grant does not cancel the operation; the response is still pulsed.
- Fairness: a requester that is continuously requesting waits for at most N_REQ-1 other operations.
  - Back-to-back requests from the same requester are granted consecutively only if no other bit is set.
- Latency: req_valid seen in IDLE at cycle 0 gives add_start at cycle 1 and resp_valid at cycle D+2, where D is the number of cycles from add_start to add_done (D >= 1). Minimum request-to-request spacing is D+3 cycles.
- Width rule: no arithmetic is done here. Results pass through unmodified; the subtract borrow appears in bit WIDTH as the adder produces it.
- grant_idx is meaningful only while busy=1 or in the cycle resp_valid is high.

Test Plan:
- Single add: requester 0, a=5, b=3, sub=0, adder model D=2 -> add_start at cycle 1 with add_subtract=0; resp_valid=2'b01 at cycle 4; resp_result=8; resp_err=0; busy low at cycle 5.
- Subtract with borrow: requester 1, a=3, b=5, sub=1 -> add_subtract=1; resp_result = {1'b1, WIDTH'(-2)}, i.e. 2^1028-2 truncated to WIDTH+1 bits from the adder model; resp_valid=2'b10.
- Contention: both requesters assert at cycle 0 and hold through 3 operations each -> grant order 0,1,0,1,0,1; every resp_valid pulse is one-hot; no back-to-back grant to the same index.
- Watchdog: adder model never pulses done -> resp_valid after ISSUE+TIMEOUT+1 cycles; resp_err=1; resp_result=0; next request is served normally.
- Reset mid-WAIT: assert resetn during WAIT, then release -> all outputs 0 immediately; no resp_valid; a late add_done is ignored; new request gets add_start 1 cycle after grant.
- Stray done and operand hold: pulse add_done in IDLE and in ISSUE -> no state change; change req_a during WAIT -> add_in_a unchanged until RESP.
